toll_sensor_uart_tx: RTL
========================

TOLL_SENSOR_UART_TX -- requirements
Module: toll_sensor_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port vehicle_detected  input  1  asynchronous sensor level, vehicle in lane.
REQ-005 The block SHALL have port tailgate  input  1  asynchronous sensor level, second vehicle too close.
REQ-006 The block SHALL have port ev_detected  input  1  asynchronous sensor level, electric vehicle tag read.
REQ-007 The block SHALL have port tx  output  1  UART serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  high while a frame is in progress (START/DATA/STOP).
REQ-009 The block SHALL have port frame_done  output  1  one-cycle pulse at end of each stop bit.

Function
REQ-010 The block SHALL pass each sensor input through a 2-flop synchronizer; the synchronized vector is sv = {vehicle_detected, tailgate, ev_detected}.
REQ-011 The block SHALL hold register last_sent[2:0], the sensor vector carried by the most recently started frame.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-013 IDLE: tx=1, busy=0; when sv != last_sent, the FSM SHALL latch shift byte = {5'b00000, sv}, set last_sent = sv, and enter START on the same edge.
REQ-014 Frame payload bit mapping SHALL be: bit2 = vehicle_detected, bit1 = tailgate, bit0 = ev_detected, bits 7:3 = 0.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 DATA SHALL send 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 frame_done SHALL be asserted for exactly one cycle, on the final cycle of STOP.
REQ-019 There SHALL be no parity bit; a frame SHALL be exactly 10*CLKS_PER_BIT cycles from first START cycle to last STOP cycle.
REQ-020 tx, busy, and frame_done SHALL be registered outputs, free of combinational glitches.
REQ-021 Latency: when an input change meets setup at edge k, tx SHALL be 0 after edge k+2, provided the FSM is IDLE at edge k+2.
REQ-022 Sensor changes during a frame SHALL NOT alter the frame in flight; sv SHALL be re-compared with last_sent on the first IDLE cycle.
REQ-023 Back-to-back operation: if sv != last_sent on the first IDLE cycle, START SHALL begin on the next cycle, giving exactly 1 idle-high cycle between frames.
REQ-024 A change that reverts before the FSM returns to IDLE (sv == last_sent) SHALL produce no frame.
REQ-025 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL reset to 0 at each bit boundary.
REQ-026 The data-bit index SHALL be 3 bits wide, with no wrap beyond bit 7.

Reset
REQ-027 During reset, outputs SHALL be tx=1, busy=0, frame_done=0; state IDLE, last_sent=3'b000, synchronizers 0, counters 0.
REQ-028 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously); the partial frame SHALL be abandoned, with no frame_done.
REQ-029 After reset release, any nonzero sv SHALL trigger a fresh frame per REQ-013.

Verification (CLKS_PER_BIT=4)
REQ-030 Sensors all 0 after reset, hold 200 cycles -> tx stays 1, busy=0, no frame_done.
REQ-031 vehicle_detected 0->1 -> frame 0x04: tx=0 for 4 cycles, then bits 0,0,1,0,0,0,0,0 for 4 cycles each, then 1 for 4 cycles; busy high 40 cycles; frame_done pulses once on cycle 40.
REQ-032 ev_detected raised at cycle 10 of the 0x04 frame -> first frame unchanged; 1 idle cycle later, frame 0x05 (bits 1,0,1,0,0,0,0,0).
REQ-033 tailgate pulsed high for 8 cycles entirely inside a frame -> no additional frame after it.
REQ-034 Reset asserted during data bit 3 with sv=3'b100 -> tx=1, busy=0 immediately; after release, a full 0x04 frame is sent with latency per REQ-021.
REQ-035 All three sensors set simultaneously from 0 -> exactly one frame 0x07, no intermediate values.

Source files
------------

// File: rtl/toll_sensor_uart_tx.sv
// Toll-lane sensor reporter: sends the synchronized sensor vector as an 8N1 UART
// frame whenever it differs from the vector carried by the last frame started.
module toll_sensor_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic vehicle_detected,
  input  logic tailgate,
  input  logic ev_detected,
  output logic tx,
  output logic busy,
  output logic frame_done
);

  // state | meaning
  // IDLE  | line high, waiting for sv to differ from last_sent
  // START | start bit (low)
  // DATA  | eight payload bits, LSB first
  // STOP  | stop bit (high); frame_done on its last cycle
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_next;
  logic [2:0]    sync1, sv;
  logic [2:0]    last_sent, last_sent_next;
  logic [7:0]    shift, shift_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          bit_end;
  logic          tx_next, busy_next, frame_done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sv    <= '0;
    end else begin
      sync1 <= {vehicle_detected, tailgate, ev_detected};
      sv    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_sent  <= '0;
      shift      <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      last_sent  <= last_sent_next;
      shift      <= shift_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      tx         <= tx_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
    end
  end

  assign bit_end = (cnt == CNT_MAX);

  always_comb begin
    state_next     = state;
    last_sent_next = last_sent;
    shift_next     = shift;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    tx_next        = 1'b1;
    busy_next      = 1'b0;
    frame_done_next = 1'b0;

    case (state)
      IDLE: begin
        if (sv != last_sent) begin
          state_next     = START;
          shift_next     = {5'b00000, sv};
          last_sent_next = sv;
          cnt_next       = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          cnt_next     = '0;
          bit_idx_next = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so derive them from where the FSM is heading.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next       = (state_next != IDLE);
    frame_done_next = (state_next == STOP) && (cnt_next == CNT_MAX);
  end

endmodule
